// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if
//   Bundles the request side and the memory-port side of the block mover.
//   Request handshake: the host holds start high with mode/src/dst/len/fill_value
//   stable; the request is taken on the rising edge where the mover is idle
//   (busy=0). While busy=1 start is ignored. Completion is a one-cycle done pulse,
//   after which busy drops and a new request may be taken on the very next edge.
//   Memory side: mem_address/mem_in/mem_load drive the single-port memory;
//   mem_out returns the word addressed on the previous rising edge.
//   state_dbg exposes the mover's FSM state for observation.
// Modports:
//   master - the mover (drives busy/done/memory port, reads request + mem_out)
//   slave  - the host/parent side (drives request + mem_out, reads the rest)
interface mem_block_mover_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;
  logic [2:0]        state_dbg;

  modport master (
    input  start, mode, src, dst, len, fill_value, mem_out,
    output busy, done, mem_address, mem_in, mem_load, state_dbg
  );

  modport slave (
    output start, mode, src, dst, len, fill_value, mem_out,
    input  busy, done, mem_address, mem_in, mem_load, state_dbg
  );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover
//   Bus initiator that copies a block of words (src -> dst, ascending order) or
//   fills a block with a constant, through a single-port memory whose read data
//   is valid one clock after the address is sampled.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - mem_block_mover_if.master: request (start/mode/src/dst/len/
//            fill_value), status (busy/done), memory port (mem_address/mem_in/
//            mem_load/mem_out) and state_dbg
// Pointers and the word counter wrap modulo 2**ADDR_W.
module mem_block_mover #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_block_mover_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fv_q, fv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, done_q, load_q;

  // Next-state and datapath updates. The copy/fill mode only steers the
  // IDLE exit; afterwards the state itself carries it, so it is not stored.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_d = bus.src;
          dst_d = bus.dst;
          cnt_d = bus.len;
          fv_d  = bus.fill_value;
          if (bus.len == '0)   state_d = S_DONE;
          else if (!bus.mode)  state_d = S_RD;
          else                 state_d = S_FILL;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? S_DONE : S_RD;
      end
      S_FILL: begin
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? S_DONE : S_FILL;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address for the upcoming state, using the already-advanced pointers,
    // so the registered address lines up with the registered state.
    case (state_d)
      S_RD:         addr_d = src_d;
      S_WR, S_FILL: addr_d = dst_d;
      default:      addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      addr_q  <= addr_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      load_q  <= (state_d == S_WR) || (state_d == S_FILL);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_load    = load_q;
  assign bus.mem_address = addr_q;
  assign bus.state_dbg   = state_q;
  // In WR the word read during the preceding RD is forwarded straight to the
  // write data; the memory's registered read makes it valid in this cycle.
  assign bus.mem_in = (state_q == S_WR)   ? bus.mem_out :
                      (state_q == S_FILL) ? fv_q        : '0;

endmodule

// File: tb/tb_mem_block_mover.sv
module tb_mem_block_mover;
  localparam int AW       = 15;
  localparam int DW       = 16;
  localparam int MEM_SIZE = 24576; // addresses >= 0x6000 are not backed by memory

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory environment ----------------
  logic [DW-1:0] mem     [MEM_SIZE];
  logic [DW-1:0] ref_mem [MEM_SIZE];
  logic          mem_init;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  function automatic logic [DW-1:0] init_word(input int i);
    return 16'((i * 40503) ^ 16'hA5A5);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_word(i);
    end else begin
      if (bd_we && int'(bd_addr) < MEM_SIZE) mem[bd_addr] <= bd_data;
      if (bus.mem_load && int'(bus.mem_address) < MEM_SIZE)
        mem[bus.mem_address] <= bus.mem_in;
    end
    bus.mem_out <= (int'(bus.mem_address) < MEM_SIZE) ? mem[bus.mem_address] : '0;
  end

  // ---------------- scoreboard / reference ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return (int'(a) < MEM_SIZE) ? ref_mem[a] : '0;
  endfunction

  task automatic ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (int'(a) < MEM_SIZE) ref_mem[a] = v;
  endtask

  task automatic chk_mem(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < MEM_SIZE; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
  endtask

  // Called at a negedge with the mover idle; ends at a negedge.
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_wr(a, v);
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge in which the mover is idle. Issues one request, then
  // watches every cycle up to and including the idle cycle after done, leaving
  // the caller at that idle negedge so the next request lands right after done.
  task automatic run_op(input string tag, input logic md, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input logic [AW-1:0] n,
                        input logic [DW-1:0] f, input bit inject);
    int k, done_n, done_at, busy_n, load_n, seq_err;
    logic [AW-1:0] ea;
    logic          el;
    k = (n == 0) ? 0 : (md ? int'(n) : 2 * int'(n));
    done_n = 0; done_at = -1; busy_n = 0; load_n = 0; seq_err = 0;

    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_addr"}, 32'(bus.mem_address), 32'd0);

    bus.start = 1'b1; bus.mode = md; bus.src = s; bus.dst = d;
    bus.len = n; bus.fill_value = f;
    @(posedge clk); #1;
    // Scramble the request lines: the mover must work from its latched copy.
    bus.start = 1'b0; bus.mode = 1'($urandom); bus.src = AW'($urandom);
    bus.dst = AW'($urandom); bus.len = AW'($urandom); bus.fill_value = DW'($urandom);

    // Reference effect: ascending word-by-word move, so overlaps replicate.
    for (int i = 0; i < int'(n); i++) begin
      if (md) ref_wr(d + AW'(i), f);
      else    ref_wr(d + AW'(i), ref_rd(s + AW'(i)));
    end

    for (int j = 0; j <= k + 1; j++) begin
      @(negedge clk);
      if (bus.done) begin done_n++; done_at = j; end
      busy_n += int'(bus.busy);
      load_n += int'(bus.mem_load);
      if (j < k) begin
        if (md) begin ea = d + AW'(j); el = 1'b1; end
        else if (j % 2 == 0) begin ea = s + AW'(j / 2); el = 1'b0; end
        else begin ea = d + AW'(j / 2); el = 1'b1; end
      end else begin
        ea = '0; el = 1'b0;
      end
      if (bus.mem_address !== ea || bus.mem_load !== el) seq_err++;
      if (md && j < k && bus.mem_in !== f) seq_err++;
      if (inject && j == 1) begin
        bus.start = 1'b1; bus.mode = ~md; bus.src = AW'($urandom);
        bus.dst = AW'($urandom); bus.len = AW'($urandom_range(1, 5));
        bus.fill_value = DW'($urandom);
      end
      if (inject && j == 2) bus.start = 1'b0;
    end

    chk({tag, "_done_count"}, 32'(done_n), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(k));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(k + 1));
    chk({tag, "_load_count"}, 32'(load_n), 32'(n));
    chk({tag, "_bus_seq_errs"}, 32'(seq_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] fv;
    logic [AW-1:0] rs, rd, rn;
    logic          rm;
    int            dn;

    reset = 1'b1; mem_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.fill_value = '0;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_load", 32'(bus.mem_load), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_din", 32'(bus.mem_in), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed copy of four words.
    poke(15'h100, 16'h1111); poke(15'h101, 16'h2222);
    poke(15'h102, 16'h3333); poke(15'h103, 16'h4444);
    run_op("copy4", 1'b0, 15'h100, 15'h200, 15'd4, 16'h0, 1'b0);
    chk("copy4_w0", 32'(mem[15'h200]), 32'h1111);
    chk("copy4_w1", 32'(mem[15'h201]), 32'h2222);
    chk("copy4_w2", 32'(mem[15'h202]), 32'h3333);
    chk("copy4_w3", 32'(mem[15'h203]), 32'h4444);
    chk_mem("copy4");

    // Directed fill of three words; the word after the block is untouched.
    run_op("fill3", 1'b1, 15'h0, 15'h050, 15'd3, 16'hBEEF, 1'b0);
    chk("fill3_w0", 32'(mem[15'h050]), 32'hBEEF);
    chk("fill3_w2", 32'(mem[15'h052]), 32'hBEEF);
    chk("fill3_after", 32'(mem[15'h053]), 32'(init_word(32'h53)));
    chk_mem("fill3");

    // Zero-length requests in both modes.
    run_op("copy0", 1'b0, 15'h010, 15'h020, 15'd0, 16'h0, 1'b0);
    run_op("fill0", 1'b1, 15'h0, 15'h030, 15'd0, 16'h1234, 1'b0);
    chk_mem("len0");

    // Destination pointer wraps from the top of the address space to zero.
    run_op("wrap", 1'b1, 15'h0, 15'h7FFF, 15'd2, 16'hCAFE, 1'b0);
    chk("wrap_w0", 32'(mem[0]), 32'hCAFE);
    chk_mem("wrap");

    // Start while busy is ignored; a request right after done is taken.
    for (int i = 0; i < 5; i++) poke(15'h120 + AW'(i), DW'($urandom));
    run_op("inj", 1'b0, 15'h120, 15'h220, 15'd5, 16'h0, 1'b1);
    run_op("b2b", 1'b1, 15'h0, 15'h240, 15'd3, 16'h5A5A, 1'b0);
    chk_mem("inj_b2b");

    // Randomized requests: random ranges, overlaps and wrapping pointers.
    for (int t = 0; t < 12; t++) begin
      rm = 1'($urandom);
      rn = AW'($urandom_range(1, 24));
      rs = AW'($urandom);
      case ($urandom_range(0, 2))
        0:       rd = rs + AW'($urandom_range(1, 3));
        1:       rd = AW'(15'h7FF8 + AW'($urandom_range(0, 7)));
        default: rd = AW'($urandom_range(0, MEM_SIZE - 1));
      endcase
      fv = DW'($urandom);
      run_op($sformatf("rnd%0d", t), rm, rs, rd, rn, fv, 1'b0);
      chk_mem($sformatf("rnd%0d", t));
    end

    // Reset in the middle of the write of word 2 of a 4-word copy.
    for (int i = 0; i < 4; i++) poke(15'h300 + AW'(i), DW'($urandom));
    bus.start = 1'b1; bus.mode = 1'b0; bus.src = 15'h300; bus.dst = 15'h400;
    bus.len = 15'd4; bus.fill_value = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_load", 32'(bus.mem_load), 32'd1);
    chk("abort_pre_addr", 32'(bus.mem_address), 32'h401);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_load", 32'(bus.mem_load), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    ref_wr(15'h400, ref_rd(15'h300));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk_mem("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
